// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: two-state instruction fetch / program counter stage.
// FETCH requests the word at pc from instruction memory. EXEC holds the
// latched instruction for decode and commits by loading next_pc.
// Optional feature macro: FETCH_PERF_CNT_EN adds the perf_retired and
// perf_redirect counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        is_bne,
  input  logic        j_type,
  input  logic        jr,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        retire
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_redirect
`endif
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic [31:0] jr_target_s;
  logic        taken_s;
  logic [31:0] next_pc_s;
  logic        retire_s;

  assign pc_plus4_s  = pc_q + 32'd4;
  assign br_target_s = pc_plus4_s + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_target_s  = {pc_plus4_s[31:28], instr_q[25:0], 2'b00};
  assign jr_target_s = {rs_data[31:2], 2'b00};
  assign taken_s     = branch & (alu_zero ^ is_bne);

  // Next-PC selection: jr over jump over taken branch over sequential.
  always_comb begin
    next_pc_s = pc_plus4_s;
    if (jr) begin
      next_pc_s = jr_target_s;
    end else if (j_type) begin
      next_pc_s = j_target_s;
    end else if (taken_s) begin
      next_pc_s = br_target_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // FSM next state, instruction latch and commit of the new pc.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (stall) begin
          state_d = S_EXEC;
        end else begin
          pc_d     = next_pc_s;
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, pc and instruction registers; reset drops any in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_q;
  assign retire      = retire_s;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_redirect_q, perf_redirect_d;

  // Counter updates: every commit, and every commit that leaves the sequential path.
  always_comb begin
    perf_retired_d  = perf_retired_q;
    perf_redirect_d = perf_redirect_q;
    if (retire_s) begin
      perf_retired_d = perf_retired_q + 32'd1;
      if (next_pc_s != pc_plus4_s) begin
        perf_redirect_d = perf_redirect_q + 32'd1;
      end else begin
        perf_redirect_d = perf_redirect_q;
      end
    end else begin
      perf_retired_d = perf_retired_q;
    end
  end

  // Performance counter registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q  <= 32'h0000_0000;
      perf_redirect_q <= 32'h0000_0000;
    end else begin
      perf_retired_q  <= perf_retired_d;
      perf_redirect_q <= perf_redirect_d;
    end
  end

  assign perf_retired  = perf_retired_q;
  assign perf_redirect = perf_redirect_q;
`endif

endmodule
